// File: rtl/tecmo_pkg.sv
// Shared types and constants for the ROM download path into SDRAM.
package tecmo_pkg;

    localparam int unsigned BYTE_ADDR_WIDTH = 25;
    localparam int unsigned WORD_ADDR_WIDTH = 23;

    // One SDRAM word write: word address and little-endian data.
    typedef struct packed {
        logic [WORD_ADDR_WIDTH-1:0] addr;
        logic [31:0]                data;
    } sdram_wr_t;

    typedef enum logic {
        W_IDLE,
        W_REQ
    } wr_state_e;

    // Replace byte lane `lane` of `word` with `val`.
    function automatic logic [31:0] insert_lane(input logic [31:0] word,
                                                input logic [1:0]  lane,
                                                input logic [7:0]  val);
        logic [31:0] res;
        res = word;
        unique case (lane)
            2'd0: res[7:0]   = val;
            2'd1: res[15:8]  = val;
            2'd2: res[23:16] = val;
            2'd3: res[31:24] = val;
            default: res = word;
        endcase
        return res;
    endfunction

endpackage

// File: rtl/rom_download_packer_if.sv
// SDRAM write port: req/ack handshake with address, data and write enable.
interface rom_download_packer_if;
    import tecmo_pkg::*;

    logic [WORD_ADDR_WIDTH-1:0] sdram_addr;
    logic [31:0]                sdram_data;
    logic                       sdram_we;
    logic                       sdram_req;
    logic                       sdram_ack;

    // The packer drives the request side.
    modport master (
        output sdram_addr,
        output sdram_data,
        output sdram_we,
        output sdram_req,
        input  sdram_ack
    );

    // The SDRAM controller accepts requests.
    modport slave (
        input  sdram_addr,
        input  sdram_data,
        input  sdram_we,
        input  sdram_req,
        output sdram_ack
    );

endinterface

// File: rtl/rom_download_packer_word_packer.sv
// Fill buffer: gathers download bytes into a 32-bit word and decides when the
// word moves on to the pending write register.
module word_packer
    import tecmo_pkg::*;
(
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       byte_valid,
    input  logic [WORD_ADDR_WIDTH-1:0] byte_word,
    input  logic [1:0]                 byte_lane,
    input  logic [7:0]                 byte_data,
    input  logic                       download,
    input  logic                       pend_free,
    output logic                       promote,
    output sdram_wr_t                  promote_wr,
    output logic                       fill_valid,
    output logic                       fill_full_next
);

    logic [31:0]                fill_data_q, fill_data_d;
    logic [WORD_ADDR_WIDTH-1:0] fill_word_q, fill_word_d;
    logic                       fill_valid_q, fill_valid_d;
    // Lane 3 landed in a fresh fill while the old fill took the pending slot;
    // that word goes out as soon as the slot frees.
    logic                       fill_full_q, fill_full_d;
    logic [31:0]                merged;

    // Lane insert and promotion decision.
    always_comb begin
        fill_data_d     = fill_data_q;
        fill_word_d     = fill_word_q;
        fill_valid_d    = fill_valid_q;
        fill_full_d     = fill_full_q;
        promote         = 1'b0;
        promote_wr.addr = fill_word_q;
        promote_wr.data = fill_data_q;
        merged          = '0;

        if (fill_valid_q && pend_free && (fill_full_q || !download)) begin
            // Deferred full word, or flush after the download ended.
            promote      = 1'b1;
            fill_data_d  = '0;
            fill_valid_d = 1'b0;
            fill_full_d  = 1'b0;
        end else if (byte_valid) begin
            if (fill_valid_q && (byte_word != fill_word_q)) begin
                promote      = 1'b1;
                fill_data_d  = insert_lane(32'h0, byte_lane, byte_data);
                fill_word_d  = byte_word;
                fill_valid_d = 1'b1;
                fill_full_d  = (byte_lane == 2'd3);
            end else begin
                merged = insert_lane(fill_valid_q ? fill_data_q : 32'h0, byte_lane, byte_data);
                if (byte_lane == 2'd3) begin
                    promote         = 1'b1;
                    promote_wr.addr = byte_word;
                    promote_wr.data = merged;
                    fill_data_d     = '0;
                    fill_valid_d    = 1'b0;
                end else begin
                    fill_data_d  = merged;
                    fill_word_d  = byte_word;
                    fill_valid_d = 1'b1;
                end
            end
        end
    end

    // Fill buffer registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            fill_data_q  <= '0;
            fill_word_q  <= '0;
            fill_valid_q <= 1'b0;
            fill_full_q  <= 1'b0;
        end else begin
            fill_data_q  <= fill_data_d;
            fill_word_q  <= fill_word_d;
            fill_valid_q <= fill_valid_d;
            fill_full_q  <= fill_full_d;
        end
    end

    assign fill_valid     = fill_valid_q;
    assign fill_full_next = fill_full_d;

endmodule

// File: rtl/rom_download_packer.sv
// Packs the byte-wide HPS ROM download into 32-bit SDRAM word writes.
module rom_download_packer #(
    parameter int unsigned BYTE_ADDR_WIDTH = tecmo_pkg::BYTE_ADDR_WIDTH,
    parameter int unsigned WORD_ADDR_WIDTH = tecmo_pkg::WORD_ADDR_WIDTH,
    parameter logic [WORD_ADDR_WIDTH-1:0] BASE_ADDR = '0
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic [BYTE_ADDR_WIDTH-1:0] ioctl_addr,
    input  logic [7:0]                 ioctl_data,
    input  logic                       ioctl_wr,
    input  logic                       ioctl_download,
    output logic                       ioctl_wait,
    rom_download_packer_if.master      sdram,
    output logic                       done
);
    import tecmo_pkg::*;

    wr_state_e state_q, state_d;
    sdram_wr_t pending_q, pending_d;
    logic      pending_valid_q, pending_valid_d;
    logic      wait_q, wait_d;
    logic      dl_q, armed_q, armed_d, done_q, done_d;

    logic      accept;
    logic      promote;
    sdram_wr_t promote_wr;
    logic      fill_valid;
    logic      fill_full_next;
    logic      fall;
    logic      all_idle;

    // Bytes strobed while throttled are dropped.
    assign accept = ioctl_wr & ioctl_download & ~wait_q;

    word_packer u_word_packer (
        .clk            (clk),
        .reset          (reset),
        .byte_valid     (accept),
        .byte_word      (ioctl_addr[BYTE_ADDR_WIDTH-1:2]),
        .byte_lane      (ioctl_addr[1:0]),
        .byte_data      (ioctl_data),
        .download       (ioctl_download),
        .pend_free      (~pending_valid_q),
        .promote        (promote),
        .promote_wr     (promote_wr),
        .fill_valid     (fill_valid),
        .fill_full_next (fill_full_next)
    );

    // Write FSM next state, pending register load/clear and throttle.
    always_comb begin
        state_d         = state_q;
        pending_d       = pending_q;
        pending_valid_d = pending_valid_q;
        unique case (state_q)
            W_IDLE: begin
                if (promote) begin
                    pending_d.addr  = promote_wr.addr + BASE_ADDR;
                    pending_d.data  = promote_wr.data;
                    pending_valid_d = 1'b1;
                    state_d         = W_REQ;
                end
            end
            W_REQ: begin
                if (sdram.sdram_ack) begin
                    pending_d       = '0;
                    pending_valid_d = 1'b0;
                    state_d         = W_IDLE;
                end
            end
            default: state_d = W_IDLE;
        endcase
        wait_d = pending_valid_d | fill_full_next;
    end

    // Completion tracking: arm on the download falling edge, fire once drained.
    always_comb begin
        fall     = dl_q & ~ioctl_download;
        all_idle = ~fill_valid & ~pending_valid_q;
        done_d   = (fall | armed_q) & all_idle;
        armed_d  = (fall | armed_q) & ~all_idle & ~ioctl_download;
    end

    // State registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q         <= W_IDLE;
            pending_q       <= '0;
            pending_valid_q <= 1'b0;
            wait_q          <= 1'b0;
            dl_q            <= 1'b0;
            armed_q         <= 1'b0;
            done_q          <= 1'b0;
        end else begin
            state_q         <= state_d;
            pending_q       <= pending_d;
            pending_valid_q <= pending_valid_d;
            wait_q          <= wait_d;
            dl_q            <= ioctl_download;
            armed_q         <= armed_d;
            done_q          <= done_d;
        end
    end

    assign sdram.sdram_req  = (state_q == W_REQ);
    assign sdram.sdram_we   = (state_q == W_REQ);
    assign sdram.sdram_addr = pending_q.addr;
    assign sdram.sdram_data = pending_q.data;
    assign ioctl_wait       = wait_q;
    assign done             = done_q;

endmodule

// File: tb/tb_rom_download_packer.sv
// Bench for rom_download_packer: two instances (base 0 and base 0x7FFFFF)
// share the download stimulus; a byte-stream model predicts every write.
module tb_rom_download_packer;

    localparam logic [22:0] BASE1 = 23'h7FFFFF;

    typedef struct {
        logic [22:0] addr;
        logic [31:0] data;
    } wr_t;

    logic        clk;
    logic        reset;
    logic [24:0] ioctl_addr;
    logic [7:0]  ioctl_data;
    logic        ioctl_wr;
    logic        ioctl_download;
    logic        wait0, wait1;
    logic        done0, done1;
    logic        ack_auto, ack_extra;

    int errors = 0;
    int total  = 0;
    int done_cnt = 0;
    int ack_cnt = 0;

    wr_t exp_q[$];
    wr_t cap0[$];
    wr_t cap1[$];

    // Model fill state (plain byte-stream rules).
    logic [22:0] m_word;
    logic [31:0] m_data;
    bit          m_valid;

    rom_download_packer_if bus0 ();
    rom_download_packer_if bus1 ();

    assign bus0.sdram_ack = ack_auto | ack_extra;
    assign bus1.sdram_ack = ack_auto | ack_extra;

    rom_download_packer #(
        .BASE_ADDR (23'h0)
    ) dut0 (
        .clk            (clk),
        .reset          (reset),
        .ioctl_addr     (ioctl_addr),
        .ioctl_data     (ioctl_data),
        .ioctl_wr       (ioctl_wr),
        .ioctl_download (ioctl_download),
        .ioctl_wait     (wait0),
        .sdram          (bus0),
        .done           (done0)
    );

    rom_download_packer #(
        .BASE_ADDR (BASE1)
    ) dut1 (
        .clk            (clk),
        .reset          (reset),
        .ioctl_addr     (ioctl_addr),
        .ioctl_data     (ioctl_data),
        .ioctl_wr       (ioctl_wr),
        .ioctl_download (ioctl_download),
        .ioctl_wait     (wait1),
        .sdram          (bus1),
        .done           (done1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        total++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, req);
        end
    endtask

    task automatic model_byte(input logic [24:0] a, input logic [7:0] d);
        logic [22:0] w;
        int lane;
        w    = a[24:2];
        lane = int'(a[1:0]);
        if (m_valid && w != m_word) begin
            exp_q.push_back('{addr: m_word, data: m_data});
            m_valid = 0;
        end
        if (!m_valid) begin
            m_word  = w;
            m_data  = 32'h0;
            m_valid = 1;
        end
        m_data[8*lane +: 8] = d;
        if (lane == 3) begin
            exp_q.push_back('{addr: m_word, data: m_data});
            m_valid = 0;
        end
    endtask

    task automatic model_end();
        if (m_valid) exp_q.push_back('{addr: m_word, data: m_data});
        m_valid = 0;
    endtask

    // Called at posedge+1; returns at posedge+1 of the cycle after the strobe.
    task automatic send_byte(input logic [24:0] a, input logic [7:0] d);
        int n;
        n = 0;
        while (wait0 && n < 100) begin
            @(posedge clk);
            #1;
            n++;
        end
        if (n >= 100) begin
            total++;
            errors++;
            $display("FAIL wait_timeout: ioctl_wait still %0b after %0d cycles", wait0, n);
        end
        ioctl_addr = a;
        ioctl_data = d;
        ioctl_wr   = 1'b1;
        @(posedge clk);
        #1;
        ioctl_wr = 1'b0;
        model_byte(a, d);
    endtask

    task automatic start_download();
        ioctl_download = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic finish_download(input string name);
        int start;
        int n;
        start = done_cnt;
        ioctl_download = 1'b0;
        model_end();
        n = 0;
        while (done_cnt == start && n < 200) begin
            @(posedge clk);
            #1;
            n++;
        end
        repeat (6) @(posedge clk);
        #1;
        chk({name, "_done_count"}, 64'(done_cnt - start), 64'd1);
        chk({name, "_writes_left"}, 64'(exp_q.size()), 64'd0);
    endtask

    // Controller model: acknowledge each request in its fourth cycle.
    initial begin
        ack_auto = 1'b0;
        forever begin
            @(posedge clk);
            #2;
            if (reset || ack_auto) begin
                ack_auto = 1'b0;
                ack_cnt  = 0;
            end else if (bus0.sdram_req) begin
                ack_cnt++;
                if (ack_cnt == 4) ack_auto = 1'b1;
            end
        end
    end

    // Per-cycle compare against the model and handshake rules.
    logic        prev_req, prev_ack;
    logic [22:0] prev_addr;
    logic [31:0] prev_data;
    always @(negedge clk) begin
        wr_t         e;
        logic [22:0] a1;
        if (reset) begin
            prev_req = 1'b0;
            prev_ack = 1'b0;
        end else begin
            chk("we0_eq_req", 64'(bus0.sdram_we), 64'(bus0.sdram_req));
            chk("we1_eq_req", 64'(bus1.sdram_we), 64'(bus1.sdram_req));
            chk("wait0_eq_req", 64'(wait0), 64'(bus0.sdram_req));
            chk("wait1_eq_req", 64'(wait1), 64'(bus1.sdram_req));
            chk("req1_eq_req0", 64'(bus1.sdram_req), 64'(bus0.sdram_req));
            chk("done1_eq_done0", 64'(done1), 64'(done0));
            if (prev_req && !prev_ack) begin
                chk("req_held", 64'(bus0.sdram_req), 64'd1);
                chk("addr_held", 64'(bus0.sdram_addr), 64'(prev_addr));
                chk("data_held", 64'(bus0.sdram_data), 64'(prev_data));
            end
            if (prev_req && prev_ack) chk("req_drop_after_ack", 64'(bus0.sdram_req), 64'd0);
            if (bus0.sdram_req && bus0.sdram_ack) begin
                cap0.push_back('{addr: bus0.sdram_addr, data: bus0.sdram_data});
                cap1.push_back('{addr: bus1.sdram_addr, data: bus1.sdram_data});
                if (exp_q.size() == 0) begin
                    total++;
                    errors++;
                    $display("FAIL unexpected_write: got addr %0h data %0h, none expected",
                             bus0.sdram_addr, bus0.sdram_data);
                end else begin
                    e  = exp_q.pop_front();
                    a1 = e.addr + BASE1;
                    chk("wr_addr0", 64'(bus0.sdram_addr), 64'(e.addr));
                    chk("wr_addr1", 64'(bus1.sdram_addr), 64'(a1));
                    chk("wr_data0", 64'(bus0.sdram_data), 64'(e.data));
                    chk("wr_data1", 64'(bus1.sdram_data), 64'(e.data));
                end
            end
            if (done0) done_cnt++;
            prev_req  = bus0.sdram_req;
            prev_ack  = bus0.sdram_ack;
            prev_addr = bus0.sdram_addr;
            prev_data = bus0.sdram_data;
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int dstart;
        reset          = 1'b1;
        ioctl_addr     = '0;
        ioctl_data     = '0;
        ioctl_wr       = 1'b0;
        ioctl_download = 1'b0;
        ack_extra      = 1'b0;
        m_valid        = 0;
        m_word         = '0;
        m_data         = '0;
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;
        @(negedge clk);
        chk("rst_req", 64'(bus0.sdram_req), 64'd0);
        chk("rst_wait", 64'(wait0), 64'd0);
        chk("rst_done", 64'(done0), 64'd0);
        chk("rst_addr", 64'(bus0.sdram_addr), 64'd0);
        chk("rst_data", 64'(bus0.sdram_data), 64'd0);
        @(posedge clk);
        #1;

        // 1: eight sequential bytes from address 0.
        cap0.delete();
        start_download();
        for (int i = 0; i < 8; i++) send_byte(25'(i), 8'(i));
        finish_download("t1");
        chk("t1_nwr", 64'(cap0.size()), 64'd2);
        if (cap0.size() == 2) begin
            chk("t1_a0", 64'(cap0[0].addr), 64'h0);
            chk("t1_d0", 64'(cap0[0].data), 64'h03020100);
            chk("t1_a1", 64'(cap0[1].addr), 64'h1);
            chk("t1_d1", 64'(cap0[1].data), 64'h07060504);
        end

        // 2: six bytes from 0x10, trailing partial word flushed.
        cap0.delete();
        start_download();
        for (int i = 0; i < 6; i++) send_byte(25'h10 + 25'(i), 8'h10 + 8'(i));
        finish_download("t2");
        chk("t2_nwr", 64'(cap0.size()), 64'd2);
        if (cap0.size() == 2) begin
            chk("t2_a0", 64'(cap0[0].addr), 64'h4);
            chk("t2_d0", 64'(cap0[0].data), 64'h13121110);
            chk("t2_a1", 64'(cap0[1].addr), 64'h5);
            chk("t2_d1", 64'(cap0[1].data), 64'h00001514);
        end

        // 3: word change promotes the partial fill.
        cap0.delete();
        start_download();
        send_byte(25'h20, 8'h20);
        send_byte(25'h21, 8'h21);
        send_byte(25'h40, 8'h40);
        finish_download("t3");
        chk("t3_nwr", 64'(cap0.size()), 64'd2);
        if (cap0.size() == 2) begin
            chk("t3_a0", 64'(cap0[0].addr), 64'h8);
            chk("t3_d0", 64'(cap0[0].data), 64'h00002120);
            chk("t3_a1", 64'(cap0[1].addr), 64'h10);
            chk("t3_d1", 64'(cap0[1].data), 64'h00000040);
        end

        // 4: base offset wraps the word address.
        cap0.delete();
        cap1.delete();
        start_download();
        for (int i = 0; i < 4; i++) send_byte(25'h4 + 25'(i), 8'hA0 + 8'(i));
        finish_download("t4");
        if (cap1.size() == 1) begin
            chk("t4_addr_wrap", 64'(cap1[0].addr), 64'h0);
            chk("t4_addr_nobase", 64'(cap0[0].addr), 64'h1);
            chk("t4_data", 64'(cap1[0].data), 64'hA3A2A1A0);
        end else begin
            chk("t4_nwr", 64'(cap1.size()), 64'd1);
        end

        // 5: reset while a request is outstanding.
        start_download();
        for (int i = 0; i < 4; i++) send_byte(25'h100 + 25'(i), 8'h50 + 8'(i));
        chk("t5_req_before_reset", 64'(bus0.sdram_req), 64'd1);
        dstart         = done_cnt;
        reset          = 1'b1;
        ioctl_download = 1'b0;
        exp_q.delete();
        m_valid = 0;
        @(posedge clk);
        #1;
        reset = 1'b0;
        @(negedge clk);
        chk("t5_req_after_reset", 64'(bus0.sdram_req), 64'd0);
        chk("t5_we_after_reset", 64'(bus0.sdram_we), 64'd0);
        chk("t5_wait_after_reset", 64'(wait0), 64'd0);
        repeat (10) @(posedge clk);
        #1;
        chk("t5_no_done", 64'(done_cnt - dstart), 64'd0);
        cap0.delete();
        start_download();
        for (int i = 0; i < 4; i++) send_byte(25'h200 + 25'(i), 8'h11 + 8'(i));
        finish_download("t5b");
        if (cap0.size() == 1) begin
            chk("t5_a", 64'(cap0[0].addr), 64'h80);
            chk("t5_d", 64'(cap0[0].data), 64'h14131211);
        end else begin
            chk("t5_nwr", 64'(cap0.size()), 64'd1);
        end

        // 6: zero-byte download, then strobes that must be ignored.
        cap0.delete();
        start_download();
        ioctl_download = 1'b0;
        @(negedge clk);
        chk("t6_done_fall_cycle", 64'(done0), 64'd0);
        @(negedge clk);
        chk("t6_done_next_cycle", 64'(done0), 64'd1);
        @(negedge clk);
        chk("t6_done_single", 64'(done0), 64'd0);
        @(posedge clk);
        #1;
        ioctl_addr = 25'h3;
        ioctl_data = 8'hEE;
        ioctl_wr   = 1'b1;
        ack_extra  = 1'b1;
        @(posedge clk);
        #1;
        ioctl_wr  = 1'b0;
        ack_extra = 1'b0;
        repeat (8) @(posedge clk);
        #1;
        chk("t6_no_req", 64'(bus0.sdram_req), 64'd0);
        chk("t6_no_writes", 64'(cap0.size()), 64'd0);

        $display("Result: errors=%0d of %0d checks", errors, total);
        $finish;
    end

endmodule
